// File: rtl/apb_mem_slave_if.sv
// APB bus bundle for apb_mem_slave; pstrb exists only when APB_MEM_SLAVE_PSTRB_EN is defined.
interface apb_mem_slave_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              psel;
    logic              pen;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
`ifdef APB_MEM_SLAVE_PSTRB_EN
    logic [DATA_W/8-1:0] pstrb;
`endif
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

`ifdef APB_MEM_SLAVE_PSTRB_EN
    modport master (output psel, pen, pwrite, paddr, pwdata, pstrb,
                    input  pready, prdata, pslverr);
    modport slave  (input  psel, pen, pwrite, paddr, pwdata, pstrb,
                    output pready, prdata, pslverr);
`else
    modport master (output psel, pen, pwrite, paddr, pwdata,
                    input  pready, prdata, pslverr);
    modport slave  (input  psel, pen, pwrite, paddr, pwdata,
                    output pready, prdata, pslverr);
`endif
endinterface

// File: rtl/apb_mem_slave.sv
// APB slave with internal word memory, programmable wait states and out-of-range pslverr.
// Optional byte-lane write strobes when APB_MEM_SLAVE_PSTRB_EN is defined.
module apb_mem_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 0
) (
    input logic            clk,
    input logic            rst,
    apb_mem_slave_if.slave bus
);
    localparam int LANES = DATA_W / 8;
    localparam int SHIFT = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] word_addr;
    logic              oor_now;
    logic              oor_p1;
    logic [IDX_W-1:0]  idx_p1;
    logic [DATA_W-1:0] prdata_p1;
    logic              launch;
    logic              stall;
    logic              complete;

    assign word_addr = bus.paddr >> SHIFT;
    assign oor_now   = (word_addr >= ADDR_W'(DEPTH));

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        stall     = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.psel) state_nxt = SETUP;
            end
            SETUP: begin
                if (bus.psel) begin
                    state_nxt = ACCESS;
                    launch    = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACCESS: begin
                // Abort and pen-drop both leave without completing, so no write can happen.
                if (!bus.psel) begin
                    state_nxt = IDLE;
                end else if (!bus.pen) begin
                    state_nxt = SETUP;
                end else if (cnt != '0) begin
                    stall = 1'b1;
                end else begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.pready  = complete;
    assign bus.pslverr = complete & oor_p1;
    assign bus.prdata  = prdata_p1;

    // SETUP -> ACCESS boundary: latch range check, wait count and read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            oor_p1    <= 1'b0;
            prdata_p1 <= '0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                cnt    <= CNT_W'(WAIT_CYCLES);
                oor_p1 <= oor_now;
                if (!bus.pwrite) begin
                    prdata_p1 <= oor_now ? '0 : mem[word_addr[IDX_W-1:0]];
                end
            end else if (stall) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (launch) idx_p1 <= word_addr[IDX_W-1:0];
    end

    // Completion boundary: commit the write; a reset on the same edge cancels it
    always_ff @(posedge clk) begin
        if (!rst && complete && bus.pwrite && !oor_p1) begin
`ifdef APB_MEM_SLAVE_PSTRB_EN
            for (int i = 0; i < LANES; i++) begin
                if (bus.pstrb[i]) mem[idx_p1][8*i +: 8] <= bus.pwdata[8*i +: 8];
            end
`else
            mem[idx_p1] <= bus.pwdata;
`endif
        end
    end
endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave: three instances (0, 2 and 3 wait states) against a word-array model.
module tb_apb_mem_slave;
    logic        clk;
    logic        rst;
    logic [2:0]  psel_d;
    logic [2:0]  pen_d;
    logic [2:0]  pwrite_d;
    logic [31:0] paddr_d  [3];
    logic [31:0] pwdata_d [3];
    logic [3:0]  pstrb_d  [3];
    logic [2:0]  pready_o;
    logic [2:0]  pslverr_o;
    logic [31:0] prdata_o [3];

    int total = 0;
    int bad   = 0;
    int wc [3] = '{0, 2, 3};
    bit [31:0] mm [3][32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        apb_mem_slave_if #(.DATA_W(32), .ADDR_W(32)) bus ();
        assign bus.psel   = psel_d[g];
        assign bus.pen    = pen_d[g];
        assign bus.pwrite = pwrite_d[g];
        assign bus.paddr  = paddr_d[g];
        assign bus.pwdata = pwdata_d[g];
`ifdef APB_MEM_SLAVE_PSTRB_EN
        assign bus.pstrb  = pstrb_d[g];
`endif
        assign pready_o[g]  = bus.pready;
        assign pslverr_o[g] = bus.pslverr;
        assign prdata_o[g]  = bus.prdata;
        apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_CYCLES(W)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] nw, input logic [3:0] strb);
        bit [31:0] r;
        r = old;
`ifdef APB_MEM_SLAVE_PSTRB_EN
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
`else
        if (strb !== 4'bxxxx) r = nw;
`endif
        return r;
    endfunction

    // One APB transfer: SETUP cycle, then ACCESS until pready; psel is left high on return.
    task automatic xfer(input int k, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input string tag);
        int idx;
        bit oor;
        bit got;
        int n;
        bit [31:0] exp_rd;
        idx    = int'(addr >> 2);
        oor    = (idx >= 32);
        exp_rd = oor ? 32'h0 : mm[k][idx];
        got    = 1'b0;
        n      = 0;
        @(negedge clk);
        psel_d[k] = 1'b1; pen_d[k] = 1'b0; pwrite_d[k] = wr;
        paddr_d[k] = addr; pwdata_d[k] = data; pstrb_d[k] = strb;
        @(negedge clk);
        pen_d[k] = 1'b1;
        while (1) begin
            #1;
            if (pready_o[k] === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (!wr && n >= 1) chk({tag, "_rd_stable"}, prdata_o[k], exp_rd);
            n++;
            if (n > 30) begin
                chk({tag, "_timeout"}, pready_o[k], 1);
                break;
            end
            @(negedge clk);
        end
        if (got) begin
            chk({tag, "_lat"}, n, 1 + wc[k]);
            chk({tag, "_err"}, pslverr_o[k], oor);
            if (!wr) chk({tag, "_rd"}, prdata_o[k], exp_rd);
            if (wr && !oor) mm[k][idx] = merge(mm[k][idx], data, strb);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        psel_d = '0;
        pen_d  = '0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit [31:0] hold_val;
        rst = 1'b1;
        psel_d = '0; pen_d = '0; pwrite_d = '0;
        for (int k = 0; k < 3; k++) begin
            paddr_d[k] = '0; pwdata_d[k] = '0; pstrb_d[k] = '0;
        end

        // Power-up reset
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst0_pready%0d", k), pready_o[k], 0);
            chk($sformatf("rst0_pslverr%0d", k), pslverr_o[k], 0);
            chk($sformatf("rst0_prdata%0d", k), prdata_o[k], 0);
        end
        rst = 1'b0;

        // Preload every word of every instance with random data, back to back
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 32; i++) xfer(k, 1, 32'(i * 4), $urandom, 4'hF, "fill");
            idle(1);
        end

        xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, "w10");
        idle(1);
        xfer(0, 0, 32'h10, 32'h0, 4'hF, "r10");
        chk("r10_const", prdata_o[0], 32'hDEADBEEF);
        idle(1);

        xfer(1, 0, 32'h04, 32'h0, 4'hF, "wait2_r04");
        idle(1);

        // Out-of-range write and read, then in-range read untouched
        xfer(0, 1, 32'h80, 32'h12345678, 4'hF, "oor_w");
        chk("oor_w_err_const", pslverr_o[0], 1);
        idle(1);
        xfer(0, 0, 32'h80, 32'h0, 4'hF, "oor_r");
        chk("oor_r_const", prdata_o[0], 0);
        idle(1);
        xfer(0, 0, 32'h00, 32'h0, 4'hF, "r00");
        idle(1);

        // Back-to-back writes with psel held high
        xfer(0, 1, 32'h0, 32'h1, 4'hF, "b2b_w0");
        xfer(0, 1, 32'h4, 32'h2, 4'hF, "b2b_w1");
        xfer(0, 0, 32'h0, 32'h0, 4'hF, "b2b_r0");
        chk("b2b_r0_const", prdata_o[0], 1);
        xfer(0, 0, 32'h4, 32'h0, 4'hF, "b2b_r1");
        chk("b2b_r1_const", prdata_o[0], 2);
        hold_val = prdata_o[0];
        idle(3);
        #1;
        chk("prdata_hold", prdata_o[0], hold_val);

        // Abort: psel dropped mid-ACCESS on the 3-wait instance
        @(negedge clk);
        psel_d[2] = 1'b1; pen_d[2] = 1'b0; pwrite_d[2] = 1'b1;
        paddr_d[2] = 32'h08; pwdata_d[2] = ~mm[2][2]; pstrb_d[2] = 4'hF;
        @(negedge clk);
        pen_d[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("abort_pready%0d", i), pready_o[2], 0);
            @(negedge clk);
        end
        psel_d[2] = 1'b0; pen_d[2] = 1'b0;
        idle(1);
        xfer(2, 0, 32'h08, 32'h0, 4'hF, "abort_rb");
        idle(1);

        // Byte strobes (full-word update when strobes are compiled out)
        xfer(0, 1, 32'h0, 32'hFFFFFFFF, 4'hF, "strb_init");
        xfer(0, 1, 32'h0, 32'h11223344, 4'b0101, "strb_w");
        xfer(0, 0, 32'h0, 32'h0, 4'hF, "strb_r");
`ifdef APB_MEM_SLAVE_PSTRB_EN
        chk("strb_const", prdata_o[0], 32'hFF22FF44);
`else
        chk("strb_const", prdata_o[0], 32'h11223344);
`endif
        xfer(0, 1, 32'h0, 32'hA5A5A5A5, 4'h0, "strb0_w");
        xfer(0, 0, 32'h0, 32'h0, 4'hF, "strb0_r");
        idle(1);

        // Reset on the completion edge of a write: write must be dropped
        xfer(1, 0, 32'h0C, 32'h0, 4'hF, "pre_rst_r");
        idle(1);
        @(negedge clk);
        psel_d[1] = 1'b1; pen_d[1] = 1'b0; pwrite_d[1] = 1'b1;
        paddr_d[1] = 32'h0C; pwdata_d[1] = ~mm[1][3]; pstrb_d[1] = 4'hF;
        @(negedge clk);
        pen_d[1] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_pre_pready", pready_o[1], 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pready", pready_o[1], 0);
        chk("rst_pslverr", pslverr_o[1], 0);
        chk("rst_prdata", prdata_o[1], 0);
        rst = 1'b0;
        psel_d = '0; pen_d = '0;
        idle(1);
        xfer(1, 0, 32'h0C, 32'h0, 4'hF, "rst_rb");
        idle(1);

        // Random traffic, occasionally back to back on the same instance
        for (int it = 0; it < 80; it++) begin
            int k;
            k = int'($urandom_range(0, 2));
            xfer(k, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 'h9F)), $urandom,
                 4'($urandom_range(0, 15)), "rnd");
            if ($urandom_range(0, 1) == 1)
                xfer(k, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 'h9F)), $urandom,
                     4'($urandom_range(0, 15)), "rnd_b2b");
            idle(int'($urandom_range(0, 2)));
        end

        // Final sweep: every word of every instance matches the model
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 32; i++) xfer(k, 0, 32'(i * 4), 32'h0, 4'hF, "sweep");
            idle(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
